// File: rtl/tick_debouncer.sv
// Tick-paced switch debouncer: a SYNC_STAGES flop synchronizer feeds a four-state
// FSM that commits a level change only after STABLE_TICKS stable timer ticks.
// Optional aborted-debounce counter port glitch_cnt: define TICK_DEBOUNCER_GLITCH_CNT_EN.
module tick_debouncer #(
   parameter int unsigned STABLE_TICKS = 3,
   parameter int unsigned SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       sw_in,
   output logic       db_level,
   output logic       db_rise,
   output logic       db_fall
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_TICKS);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_in;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
   logic [7:0]             glitch_q, glitch_d;
   logic                   abort;
`endif

   assign sync_d = {sync_q[SYNC_STAGES-2:0], sw_in};
   assign s_in   = sync_q[SYNC_STAGES-1];

   // A level change on s_in always beats a tick that arrives in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cnt_inc = cnt_q + CNT_W'(1);
      case (state_q)
         ZERO: begin
            if (s_in) begin
               state_d = WAIT1;
               cnt_d   = '0;
            end
         end
         WAIT1: begin
            if (!s_in) begin
               state_d = ZERO;
            end else if (tick) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_DONE) state_d = ONE;
            end
         end
         ONE: begin
            if (!s_in) begin
               state_d = WAIT0;
               cnt_d   = '0;
            end
         end
         WAIT0: begin
            if (s_in) begin
               state_d = ONE;
            end else if (tick) begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_DONE) state_d = ZERO;
            end
         end
         default: begin
            state_d = ZERO;
            cnt_d   = '0;
         end
      endcase

      level_d = (state_d == ONE) || (state_d == WAIT0);
      rise_d  = (state_q == WAIT1) && (state_d == ONE);
      fall_d  = (state_q == WAIT0) && (state_d == ZERO);
   end

`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
   // Aborted debounces only; saturates rather than wrapping.
   always_comb begin
      abort    = ((state_q == WAIT1) && (state_d == ZERO)) ||
                 ((state_q == WAIT0) && (state_d == ONE));
      glitch_d = glitch_q;
      if (abort && (glitch_q != 8'hFF)) glitch_d = glitch_q + 8'd1;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q   <= '0;
         state_q  <= ZERO;
         cnt_q    <= '0;
         level_q  <= 1'b0;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
         glitch_q <= 8'd0;
`endif
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         level_q  <= level_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
         glitch_q <= glitch_d;
`endif
      end
   end

   assign db_level = level_q;
   assign db_rise  = rise_q;
   assign db_fall  = fall_q;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
   assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_tick_debouncer.sv
// Bench for tick_debouncer: a STABLE_TICKS=3 instance driven by a 10-clk tick
// (auto or hand-pulsed) and a STABLE_TICKS=1 instance on a 5-clk tick.
`timescale 1ns/1ps
module tb_tick_debouncer;

   localparam int ST      = 3;
   localparam int SYNC    = 2;
   localparam int TICK_P  = 10;
   localparam int TICK_P1 = 5;

   logic clk = 1'b0;
   logic reset;
   logic tick, sw_in, db_level, db_rise, db_fall;
   logic tick1, sw_in1, db_level1, db_rise1, db_fall1;
   logic tick_en, tick_man, tick_auto, tick_auto1;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
   logic [7:0] glitch_cnt, glitch_cnt1;
`endif

   int tick_ph, tick_ph1, cyc;
   int errors = 0;
   int checks = 0;
   int rise_n = 0, fall_n = 0, rise1_n = 0, fall1_n = 0;
   logic [1:0] exp_q[$];

   assign tick  = tick_auto | tick_man;
   assign tick1 = tick_auto1;

   tick_debouncer #(.STABLE_TICKS(ST), .SYNC_STAGES(SYNC)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick),
      .sw_in    (sw_in),
      .db_level (db_level),
      .db_rise  (db_rise),
      .db_fall  (db_fall)
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt)
`endif
   );

   tick_debouncer #(.STABLE_TICKS(1), .SYNC_STAGES(SYNC)) u_dut1 (
      .clk      (clk),
      .reset    (reset),
      .tick     (tick1),
      .sw_in    (sw_in1),
      .db_level (db_level1),
      .db_rise  (db_rise1),
      .db_fall  (db_fall1)
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      ,
      .glitch_cnt (glitch_cnt1)
`endif
   );

   // clock / reset-independent timebase
   initial forever #5 clk = ~clk;

   initial begin
      tick_auto  = 1'b0;
      tick_auto1 = 1'b0;
      tick_ph    = 0;
      tick_ph1   = 0;
      cyc        = 0;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         tick_ph    = (tick_ph == TICK_P - 1) ? 0 : tick_ph + 1;
         tick_ph1   = (tick_ph1 == TICK_P1 - 1) ? 0 : tick_ph1 + 1;
         tick_auto  = tick_en && (tick_ph == TICK_P - 1);
         tick_auto1 = (tick_ph1 == TICK_P1 - 1);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // scoreboard: every pulse pops one expected event {rise,fall}
   always @(negedge clk) begin
      if (db_rise)  rise_n++;
      if (db_fall)  fall_n++;
      if (db_rise1) rise1_n++;
      if (db_fall1) fall1_n++;
      if (db_rise || db_fall) begin
         if (exp_q.size() == 0) check("pulse_unexp", int'({db_rise, db_fall}), 0);
         else                   check("pulse_type", int'({db_rise, db_fall}), int'(exp_q.pop_front()));
         check("pulse_level", int'(db_level), int'(db_rise));
      end
   end

   task automatic tick_pulse();
      @(posedge clk); #1; tick_man = 1'b1;
      @(posedge clk); #1; tick_man = 1'b0;
   endtask

   task automatic wait_level(input logic val, input int budget, output int lat);
      int start;
      start = cyc;
      lat   = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (db_level == val) begin
            lat = cyc - start;
            break;
         end
      end
      if (lat < 0) check("level_timeout", int'(db_level), int'(val));
   endtask

   task automatic step_sw(input logic val, input string tag);
      int lat, r0, f0, d;
      @(posedge clk); #1;
      r0 = rise_n;
      f0 = fall_n;
      exp_q.push_back(val ? 2'b10 : 2'b01);
      sw_in = val;
      wait_level(val, 60, lat);
      d = lat - SYNC;
      check({tag, "_lat_ok"}, int'((d >= (ST - 1) * TICK_P + 1) && (d <= ST * TICK_P + 1)), 1);
      repeat (5) @(negedge clk);
      check({tag, "_level"}, int'(db_level), int'(val));
      check({tag, "_rise_n"}, rise_n - r0, int'(val));
      check({tag, "_fall_n"}, fall_n - f0, int'(!val));
   endtask

   task automatic st1_step(input logic val, input string tag);
      int k, r0, f0;
      logic t, lvl_prev, found;
      @(posedge clk); #1;
      r0 = rise1_n;
      f0 = fall1_n;
      sw_in1   = val;
      k        = 0;
      found    = 1'b0;
      lvl_prev = db_level1;
      while (k < 30 && !found) begin
         @(negedge clk);
         t        = tick1;
         lvl_prev = db_level1;
         @(posedge clk);
         k++;
         if (k >= 4 && t) found = 1'b1;
      end
      #1;
      check({tag, "_found"}, int'(found), 1);
      check({tag, "_early"}, int'(lvl_prev), int'(!val));
      check({tag, "_level"}, int'(db_level1), int'(val));
      repeat (3) @(posedge clk); #1;
      check({tag, "_rise_n"}, rise1_n - r0, int'(val));
      check({tag, "_fall_n"}, fall1_n - f0, int'(!val));
   endtask

   initial begin
      int r0, g0;
      reset    = 1'b1;
      sw_in    = 1'b0;
      sw_in1   = 1'b0;
      tick_man = 1'b0;
      tick_en  = 1'b1;
      g0       = 0;

      repeat (3) @(posedge clk); #1;
      check("rst_level", int'(db_level), 0);
      check("rst_rise", int'(db_rise), 0);
      check("rst_fall", int'(db_fall), 0);
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      check("rst_glitch", int'(glitch_cnt), 0);
`endif
      reset = 1'b0;
      repeat (5) @(posedge clk); #1;

      // clean press and release at a random tick phase
      repeat ($urandom_range(0, 9)) @(posedge clk);
      step_sw(1'b1, "press");
      repeat ($urandom_range(0, 9)) @(posedge clk);
      step_sw(1'b0, "release");

      // bounce: five short high pulses, then settle high
      @(posedge clk); #1;
      r0 = rise_n;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      g0 = int'(glitch_cnt);
`endif
      for (int i = 0; i < 10; i++) begin
         sw_in = ~sw_in;
         repeat (4) @(posedge clk); #1;
      end
      check("bounce_no_rise", rise_n - r0, 0);
      check("bounce_level", int'(db_level), 0);
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      check("bounce_glitch", int'(glitch_cnt) - g0, 5);
`endif
      step_sw(1'b1, "settle");
      step_sw(1'b0, "rel2");

      // hand-pulsed ticks: s_in drop coincides with the 3rd tick
      tick_en = 1'b0;
      repeat (3) @(posedge clk); #1;
      r0 = rise_n;
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      g0 = int'(glitch_cnt);
`endif
      sw_in = 1'b1;
      repeat (4) @(posedge clk); #1;
      tick_pulse();
      tick_pulse();
      check("sim_two_ticks", int'(db_level), 0);
      sw_in = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      tick_man = 1'b1;
      @(posedge clk); #1;
      tick_man = 1'b0;
      repeat (4) @(posedge clk); #1;
      check("sim_level", int'(db_level), 0);
      check("sim_no_rise", rise_n - r0, 0);
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      check("sim_glitch", int'(glitch_cnt) - g0, 1);
`endif
      // a fresh debounce after the abort needs all three ticks again
      sw_in = 1'b1;
      repeat (4) @(posedge clk); #1;
      tick_pulse();
      tick_pulse();
      check("recnt_two", int'(db_level), 0);
      exp_q.push_back(2'b10);
      tick_pulse();
      check("recnt_three", int'(db_level), 1);

      // asynchronous reset from ONE: outputs clear without a clock edge
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("rst_async_level", int'(db_level), 0);
      check("rst_async_rise", int'(db_rise), 0);
      check("rst_async_fall", int'(db_fall), 0);
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      check("rst_async_glitch", int'(glitch_cnt), 0);
`endif
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk); #1;
      tick_pulse();
      tick_pulse();
      check("rst_from_zero", int'(db_level), 0);

      // reset mid-WAIT1 after two ticks discards the partial count
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("rst_mid_level", int'(db_level), 0);
      check("rst_mid_rise", int'(db_rise), 0);
      repeat (2) @(posedge clk); #1;
      reset = 1'b0;
      repeat (4) @(posedge clk); #1;
      tick_pulse();
      tick_pulse();
      check("post_rst_two", int'(db_level), 0);
      exp_q.push_back(2'b10);
      tick_pulse();
      check("post_rst_three", int'(db_level), 1);
      repeat (3) @(posedge clk); #1;

      // STABLE_TICKS=1 instance
      repeat ($urandom_range(0, 4)) @(posedge clk);
      st1_step(1'b1, "st1_up");
      repeat ($urandom_range(0, 4)) @(posedge clk);
      st1_step(1'b0, "st1_down");
`ifdef TICK_DEBOUNCER_GLITCH_CNT_EN
      check("st1_glitch", int'(glitch_cnt1), 0);
`endif

      repeat (5) @(posedge clk); #1;
      check("exp_left", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
